axi_write_arbiter: RTL

//  Shares one simplified AXI-lite write port (AW, W, B) between N_REQ requesters using round-robin arbitration.
//  The B channel carries no ID, so responses return in order. A small in-order FIFO of requester indices

---
 rtl/axi_transaction.sv | 19 +
 rtl/axi_resp_id_fifo.sv | 57 +++++
 rtl/axi_write_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/axi_transaction.sv
// Shared AXI-lite write types plus the arbiter FSM state and round-robin pick helper.
package axi_transaction;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;

    typedef enum logic {IDLE, ISSUE} arb_state_t;

    // First asserted index strictly after 'last', wrapping n-1 -> 0; -1 when mask is empty.
    function automatic int rr_pick(input logic [7:0] mask, input int last, input int n);
        int pick;
        pick = -1;
        for (int i = 1; i <= 8; i++) begin
            if (i <= n && pick < 0 && mask[(last + i) % n]) pick = (last + i) % n;
        end
        return pick;
    endfunction

endpackage

// File: rtl/axi_resp_id_fifo.sv
// In-order FIFO of requester indices; the head names the owner of the next B response.
module axi_resp_id_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= inc(wr_q);
            if (do_pop)  rd_q <= inc(rd_q);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset: entries are only read behind a valid count.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end

    assign dout  = mem_q[rd_q];
    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;

endmodule

// File: rtl/axi_write_arbiter.sv
// Round-robin arbiter sharing one AXI-lite write port among N_REQ requesters;
// B responses are routed back in order through an index FIFO.
module axi_write_arbiter
    import axi_transaction::*;
#(
    parameter int N_REQ   = 4,
    parameter int MAX_OUT = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_REQ-1:0]             req_valid,
    input  addr_t [N_REQ-1:0]            req_addr,
    input  data_t [N_REQ-1:0]            req_data,
    output logic [N_REQ-1:0]             req_ready,
    output logic [N_REQ-1:0]             resp_valid,
    output addr_t                        awaddr,
    output logic                         awvalid,
    input  logic                         awready,
    output data_t                        wdata,
    output logic                         wvalid,
    input  logic                         wready,
    input  logic                         bvalid,
    output logic                         bready,
    output logic [$clog2(MAX_OUT+1)-1:0] outstanding,
    output logic                         protocol_err
);
    localparam int IDX_W = $clog2(N_REQ);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;     // next-priority index, i.e. last grantee + 1
    logic [IDX_W-1:0] gnt_idx, head;
    logic             aw_done_q, aw_done_d, w_done_q, w_done_d;
    addr_t            addr_q, addr_d;
    data_t            data_q, data_d;
    logic [N_REQ-1:0] resp_q, resp_d;
    logic             perr_q, perr_d;
    logic             grant, pop, full, empty;
    int               last;

    axi_resp_id_fifo #(.DEPTH(MAX_OUT), .W(IDX_W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (grant),
        .din   (gnt_idx),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (outstanding)
    );

    always_comb begin
        last      = (int'(ptr_q) + N_REQ - 1) % N_REQ;
        gnt_idx   = IDX_W'(rr_pick(8'(req_valid), last, N_REQ));
        // rst_n gate keeps req_ready low while reset is asserted
        grant     = rst_n && (state_q == IDLE) && (|req_valid) && !full;
        pop       = bvalid && !empty;
        req_ready = '0;
        if (grant) req_ready[gnt_idx] = 1'b1;

        state_d   = state_q;
        ptr_d     = ptr_q;
        addr_d    = addr_q;
        data_d    = data_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d   = ISSUE;
                    ptr_d     = (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                    addr_d    = req_addr[gnt_idx];
                    data_d    = req_data[gnt_idx];
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            ISSUE: begin
                aw_done_d = aw_done_q | (awvalid & awready);
                w_done_d  = w_done_q | (wvalid & wready);
                if (aw_done_d && w_done_d) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        resp_d = '0;
        if (pop) resp_d[head] = 1'b1;
        perr_d = perr_q | (bvalid & empty);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            resp_q    <= '0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            resp_q    <= resp_d;
            perr_q    <= perr_d;
        end
    end

    assign awvalid      = (state_q == ISSUE) && !aw_done_q;
    assign wvalid       = (state_q == ISSUE) && !w_done_q;
    assign awaddr       = addr_q;
    assign wdata        = data_q;
    assign bready       = !empty;
    assign resp_valid   = resp_q;
    assign protocol_err = perr_q;

endmodule
